spi_master_gen: RTL



---
 rtl/spi_master_gen.sv | 137 +++++++++++++
 1 files changed

// File: rtl/spi_master_gen.sv
// SPI master that runs one full-duplex frame per accepted start pulse.
// It supports all CPOL/CPHA modes, either bit order, a programmable SCK half-period and one-hot slave selects.
//   state | meaning
//   IDLE  | waiting for start; sck tracks cpol, all selects high
//   SETUP | select asserted, half-period H0 before the first SCK edge
//   XFER  | SCK edges 1..2*DATA_W, sample/shift per cpha
//   HOLD  | last half-period with select held, then done
module spi_master_gen #(
    parameter int DATA_W = 8,
    parameter int SS_N   = 8,
    parameter int DIV_W  = 8,
    localparam int SEL_W = $clog2(SS_N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SEL_W-1:0]  ss_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  div,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    input  logic              miso,
    output logic              mosi,
    output logic              sck,
    output logic [SS_N-1:0]   ssn
);

    localparam int EDGE_W = $clog2(2 * DATA_W + 2);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t              r_state;
    logic [DIV_W:0]      r_cnt;
    logic [DIV_W-1:0]    r_div;
    logic [EDGE_W-1:0]   r_edge;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx;
    logic                r_cpha;
    logic                r_lsb;

    logic [31:0]         w_sel_ext;
    logic                w_accept;
    logic                w_tick;
    logic [EDGE_W-1:0]   w_k;
    logic                w_next_bit;
    logic [DATA_W-1:0]   w_tx_shift;
    logic [DATA_W-1:0]   w_rx_shift;
    logic                w_in_first;
    logic [DATA_W-1:0]   w_in_shift;

    assign w_sel_ext  = 32'(ss_sel);
    assign w_accept   = start && (w_sel_ext < 32'(SS_N));
    assign w_tick     = (r_cnt == '0);
    assign w_k        = r_edge + EDGE_W'(1);
    assign w_next_bit = r_lsb ? r_tx[0] : r_tx[DATA_W-1];
    assign w_tx_shift = r_lsb ? {1'b0, r_tx[DATA_W-1:1]} : {r_tx[DATA_W-2:0], 1'b0};
    assign w_rx_shift = r_lsb ? {miso, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], miso};
    assign w_in_first = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
    assign w_in_shift = lsb_first ? {1'b0, tx_data[DATA_W-1:1]} : {tx_data[DATA_W-2:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_div   <= '0;
            r_edge  <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_cpha  <= 1'b0;
            r_lsb   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
            mosi    <= 1'b0;
            sck     <= 1'b0;
            ssn     <= '1;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    sck  <= cpol;
                    mosi <= 1'b0;
                    if (w_accept) begin
                        // H0 is one cycle longer because the accept cycle itself is not counted
                        r_cnt   <= {1'b0, div} + (DIV_W+1)'(1);
                        r_div   <= div;
                        r_edge  <= '0;
                        r_cpha  <= cpha;
                        r_lsb   <= lsb_first;
                        r_rx    <= '0;
                        busy    <= 1'b1;
                        ssn     <= ~(SS_N'(1) << ss_sel);
                        if (!cpha) begin
                            mosi <= w_in_first;
                            r_tx <= w_in_shift;
                        end else begin
                            r_tx <= tx_data;
                        end
                        r_state <= SETUP;
                    end
                end
                SETUP, XFER, HOLD: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - (DIV_W+1)'(1);
                    end else begin
                        r_cnt  <= {1'b0, r_div};
                        r_edge <= w_k;
                        if (r_state == HOLD) begin
                            rx_data <= r_rx;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            ssn     <= '1;
                            mosi    <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            sck <= ~sck;
                            // sample edges are odd for cpha=0 and even for cpha=1
                            if (w_k[0] != r_cpha) begin
                                r_rx <= w_rx_shift;
                            end else if (w_k != EDGE_W'(2 * DATA_W)) begin
                                mosi <= w_next_bit;
                                r_tx <= w_tx_shift;
                            end
                            r_state <= (w_k == EDGE_W'(2 * DATA_W)) ? HOLD : XFER;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
